tribus_arbiter: RTL and testbench
=================================

# tribus_arbiter

Round-robin arbiter and turnaround sequencer for a shared bidirectional (inout) bus driven by up to N_REQ agents. It grants one agent at a time and produces that agent's output-enable. Every ownership change passes through a guaranteed all-disabled turnaround window, so two drivers never overlap on the wires. It sits beside the bus pads: agents raise requests, and the arbiter returns a one-hot grant/enable plus the owner index.

## Interface
- N_REQ, 4, number of requesting agents (2..8)
- TURN_CYC, 1, turnaround cycles with all enables low between owners (1..7)
- MAX_HOLD, 16, maximum cycles one owner may hold the bus while others wait (2..255)

Ports:
- clk  input  1  bus clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  N_REQ  per-agent request level, held until granted and finished
- done  input  N_REQ  per-agent single-cycle release pulse; only the owner's bit is honoured
- gnt  output  N_REQ  one-hot grant, registered
- oe  output  N_REQ  one-hot drive enable, registered, equal to gnt during OWN
- owner  output  $clog2(N_REQ)  index of current/last owner
- busy  output  1  high in TURN or OWN
- preempt  output  1  one-cycle pulse when ownership is revoked by hold timeout

## Operation
- States: IDLE, TURN, OWN.
- Reset values: state IDLE, gnt 0, oe 0, owner 0, busy 0, preempt 0. The round-robin pointer resets to N_REQ-1, so agent 0 has first priority.
- IDLE: if any req is high, the arbiter selects the winner round-robin. The winner is the first set req bit at an index above the pointer, wrapping around. It latches the winner into owner, loads the turn counter with TURN_CYC-1, and goes to TURN. With no req it stays in IDLE.
- TURN: gnt=0, oe=0, busy=1. The turn counter decrements each cycle. When it reaches 0, the FSM goes to OWN.
- Entry to OWN: gnt[owner]=1, oe[owner]=1, hold counter=0, pointer=owner.
- OWN: the hold counter increments each cycle and saturates at MAX_HOLD. Release occurs on any of:
  - done[owner]=1
  - req[owner]=0 (requester withdrew)
  - hold counter = MAX_HOLD-1 while any other req is high; this sets preempt=1 on the release edge
- On release, gnt and oe drop on the next edge.
  - If any req is high (excluding the releasing owner's bit, unless it is the sole requester), the arbiter selects the next owner immediately and goes to TURN.
  - Otherwise it goes to IDLE.
- A sole requester whose hold counter reaches MAX_HOLD is not preempted. It keeps the bus and the counter saturates.
- done on non-owner bits is ignored. done during TURN or IDLE is ignored.
- Requests that arrive during TURN do not change the already-latched next owner.
- Invariants: oe is always zero or one-hot. oe is never nonzero in the cycle immediately after a different owner's oe was high.
- Reset mid-operation: all outputs clear asynchronously on rst_n low. The FSM resumes from IDLE with pointer N_REQ-1.

## Timing
- Request to grant: req sampled high in IDLE at edge k gives TURN from k+1, and gnt/oe high at edge k+1+TURN_CYC.
- Release to next enable: done at edge k drops oe at k+1, and the next owner's oe rises at k+1+TURN_CYC. That leaves exactly TURN_CYC cycles with all oe low.
- Maximum wait for any persistent requester: (N_REQ-1)·(MAX_HOLD+TURN_CYC) + TURN_CYC cycles.
- preempt is asserted in the same cycle that gnt/oe are still high for the final time; it is combinationally registered with the release decision.

## Test plan
- Single request: TURN_CYC=1, req=0001 at cycle 2. Required: gnt=oe=0001 from cycle 4, busy=1 from cycle 3. A done[0] pulse at cycle 8 gives oe=0 at cycle 9, then IDLE, busy=0.
- Round-robin fairness: req=1111 held, each owner pulses done 3 cycles after grant. Required grant order 0,1,2,3,0, with exactly 1 all-zero oe cycle between owners.
- Preemption: MAX_HOLD=4, req=0011 held, no done. Required: owner 0 has oe for 4 cycles, preempt pulses on the last one, then TURN, then owner 1 for 4 cycles, then back to 0.
- Sole holder: MAX_HOLD=4, req=0100 only, held for 20 cycles. Required: oe=0100 continuously, preempt never asserted.
- Withdrawal and stray done: owner 2 drops req with done=1000 asserted simultaneously. Required: release on withdrawal, done[3] ignored, and agent 3's later grant follows normal round-robin from pointer 2.
- Reset mid-OWN: assert rst_n=0 while oe=0010. Required: oe, gnt, busy and owner go to 0 immediately. After release with req=0011, agent 0 is granted first.

Source files
------------

// File: rtl/tribus_arbiter.sv
// tribus_arbiter: round-robin owner selection for a shared inout bus with
// a forced all-disabled turnaround window between successive drivers.
module tribus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int TURN_CYC = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         done,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         oe,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy,
    output logic                     preempt
);

    localparam int OW = $clog2(N_REQ);
    localparam int TW = $clog2(TURN_CYC + 1);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE,
        TURN,
        OWN
    } state_t;

    state_t           state_q, state_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic [OW-1:0]    ptr_q, ptr_d;
    logic [TW-1:0]    turn_q, turn_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             busy_q, busy_d;

    logic [N_REQ-1:0] own_oh;
    logic [N_REQ-1:0] others;
    logic [N_REQ-1:0] cand;
    logic             any_other;
    logic             hold_out;
    logic             rel;

    // First set bit strictly after p, wrapping; p itself has lowest priority.
    function automatic logic [OW-1:0] rr_pick(
        input logic [N_REQ-1:0] m,
        input logic [OW-1:0]    p
    );
        logic [OW-1:0] w;
        logic [OW-1:0] k;
        logic          hit;
        w   = p;
        hit = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            k = OW'((int'(p) + i) % N_REQ);
            if (!hit && m[k]) begin
                w   = k;
                hit = 1'b1;
            end
        end
        return w;
    endfunction

    always_comb begin
        own_oh    = N_REQ'(1) << owner_q;
        others    = req & ~own_oh;
        any_other = |others;
        hold_out  = (hold_q >= HW'(MAX_HOLD - 1)) && any_other;
        rel       = done[owner_q] || !req[owner_q] || hold_out;
        // The releasing owner only competes again when nobody else waits.
        cand      = any_other ? others : req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= OW'(N_REQ - 1);
            turn_q  <= '0;
            hold_q  <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            turn_q  <= turn_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        turn_d  = turn_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d = rr_pick(req, ptr_q);
                    turn_d  = TW'(TURN_CYC - 1);
                    state_d = TURN;
                end
            end
            TURN: begin
                if (turn_q == '0) begin
                    state_d = OWN;
                    hold_d  = '0;
                    ptr_d   = owner_q;
                end else begin
                    turn_d = turn_q - 1'b1;
                end
            end
            OWN: begin
                if (hold_q != HW'(MAX_HOLD)) begin
                    hold_d = hold_q + 1'b1;
                end
                if (rel) begin
                    if (|cand) begin
                        owner_d = rr_pick(cand, ptr_q);
                        turn_d  = TW'(TURN_CYC - 1);
                        state_d = TURN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d   = '0;
        busy_d  = (state_d != IDLE);
        preempt = (state_q == OWN) && hold_out;
        if (state_d == OWN) begin
            gnt_d = N_REQ'(1) << owner_d;
        end
    end

    assign gnt   = gnt_q;
    assign oe    = gnt_q;
    assign owner = owner_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_tribus_arbiter.sv
// tb_tribus_arbiter: vector table with hand-derived expectations routed
// through a scoreboard queue, plus an asynchronous mid-ownership reset.
module tb_tribus_arbiter;

    localparam int N  = 4;
    localparam int TC = 1;
    localparam int MH = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] gnt;
    logic [N-1:0] oe;
    logic [1:0]   owner;
    logic         busy;
    logic         preempt;

    tribus_arbiter #(
        .N_REQ   (N),
        .TURN_CYC(TC),
        .MAX_HOLD(MH)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .done   (done),
        .gnt    (gnt),
        .oe     (oe),
        .owner  (owner),
        .busy   (busy),
        .preempt(preempt)
    );

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] done;
        logic [N-1:0] oe;
        logic [1:0]   owner;
        logic         busy;
        logic         pre;
    } vec_t;

    vec_t         vecs[$];
    vec_t         sb[$];
    int           checks;
    int           errors;
    logic [N-1:0] prev_oe;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [N-1:0] r, input logic [N-1:0] d,
                       input logic [N-1:0] o, input logic [1:0] ow,
                       input logic b, input logic p);
        vec_t v;
        v.req   = r;
        v.done  = d;
        v.oe    = o;
        v.owner = ow;
        v.busy  = b;
        v.pre   = p;
        vecs.push_back(v);
    endtask

    // Each row: inputs applied during a cycle and outputs seen in that cycle.
    task automatic run_vecs(input string ph);
        vec_t e;
        logic ovl;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            req  = vecs[i].req;
            done = vecs[i].done;
            sb.push_back(vecs[i]);
            #1;
            e = sb.pop_front();
            chk($sformatf("%s[%0d].oe", ph, i), oe, e.oe);
            chk($sformatf("%s[%0d].gnt", ph, i), gnt, e.oe);
            chk($sformatf("%s[%0d].owner", ph, i), owner, e.owner);
            chk($sformatf("%s[%0d].busy", ph, i), busy, e.busy);
            chk($sformatf("%s[%0d].preempt", ph, i), preempt, e.pre);
            chk($sformatf("%s[%0d].onehot", ph, i), $onehot0(oe), 1);
            ovl = (prev_oe != '0) && (oe != '0) && (oe != prev_oe);
            chk($sformatf("%s[%0d].overlap", ph, i), ovl, 0);
            prev_oe = oe;
        end
        vecs.delete();
    endtask

    initial begin
        logic [N-1:0] oh;
        checks  = 0;
        errors  = 0;
        prev_oe = '0;
        rst_n   = 1'b0;
        req     = '0;
        done    = '0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst.oe", oe, 0);
        chk("rst.gnt", gnt, 0);
        chk("rst.owner", owner, 0);
        chk("rst.busy", busy, 0);
        chk("rst.preempt", preempt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // fairness: all request, each owner releases at hold 2
        add(4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        for (int a = 0; a < N; a++) begin
            oh = 4'(1 << a);
            add(4'b1111, 4'b0000, 4'b0000, 2'(a), 1'b1, 1'b0);
            add(4'b1111, 4'b0000, oh, 2'(a), 1'b1, 1'b0);
            add(4'b1111, 4'b0000, oh, 2'(a), 1'b1, 1'b0);
            add(4'b1111, oh, oh, 2'(a), 1'b1, 1'b0);
        end
        add(4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0);
        add(4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(4'b0000, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

        // single request with done
        add(4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        add(4'b0001, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            add(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(4'b0000, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

        // sole holder never preempted
        add(4'b0100, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        add(4'b0100, 4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++)
            add(4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
        add(4'b0000, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
        add(4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);

        // withdrawal, stray done on non-owner and during TURN
        add(4'b0100, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0);
        add(4'b0100, 4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0);
        add(4'b1101, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
        add(4'b1001, 4'b1000, 4'b0100, 2'd2, 1'b1, 1'b0);
        add(4'b1001, 4'b0000, 4'b0000, 2'd3, 1'b1, 1'b0);
        add(4'b1001, 4'b0001, 4'b1000, 2'd3, 1'b1, 1'b0);
        add(4'b1001, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0);
        add(4'b0001, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0);
        add(4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b0);
        add(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(4'b0000, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);

        // agent 1 takes the bus, then reset hits mid-ownership
        add(4'b0010, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        add(4'b0010, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0);
        add(4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0);
        run_vecs("p1");

        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.oe", oe, 0);
        chk("arst.gnt", gnt, 0);
        chk("arst.owner", owner, 0);
        chk("arst.busy", busy, 0);
        chk("arst.preempt", preempt, 0);
        @(negedge clk);
        req  = '0;
        done = '0;
        #1;
        chk("arst_hold.oe", oe, 0);
        chk("arst_hold.busy", busy, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        prev_oe = '0;

        // preemption ping-pong between agents 0 and 1
        add(4'b0011, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        add(4'b0011, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            add(4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b1);
        add(4'b0011, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            add(4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0);
        add(4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b1);
        add(4'b0011, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0);
        add(4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0);
        add(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        run_vecs("p2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
